// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, valid/ready in,
// single-cycle result pulse out, with optional two's-complement input and leading-zero mask.
module bin_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  dout_vld
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  // Every digit above the ones digit blanked, the ones digit always shown.
  localparam logic [DIGITS-1:0] LzRst = ~DIGITS'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  sr_q;
  logic [BcdW-1:0]   scr_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q;

  logic [BcdW-1:0]   bcd_q;
  logic              sign_q;
  logic [DIGITS-1:0] lz_q;
  logic              dout_vld_q;

  logic              accept;
  logic              neg_in;
  logic [BIN_W-1:0]  mag;
  logic [BcdW-1:0]   adj;
  logic [DIGITS-1:0] lz_calc;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (din_vld) state_d = StShift;
      StShift: if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    din_rdy = (state_q == StIdle);
  end

  // ---------------------------------------------------------------------------
  // Operand capture and shift-add-3 datapath
  // ---------------------------------------------------------------------------
  assign accept = (state_q == StIdle) && din_vld;
  assign neg_in = (SIGNED != 0) && bin_in[BIN_W-1];
  // The most negative input negates to itself, which read unsigned is the correct magnitude.
  assign mag    = neg_in ? (~bin_in + BIN_W'(1)) : bin_in;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      sr_q  <= mag;
      scr_q <= '0;
      cnt_q <= CntW'(BIN_W);
      neg_q <= neg_in;
    end else if (state_q == StShift) begin
      scr_q <= {adj[BcdW-2:0], sr_q[BIN_W-1]};
      sr_q  <= {sr_q[BIN_W-2:0], 1'b0};
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_calc  = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero   = all_zero && (scr_q[4*i +: 4] == 4'd0);
      lz_calc[i] = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      lz_q       <= LzRst;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= (state_q == StDone);
      if (state_q == StDone) begin
        bcd_q  <= scr_q;
        // Zero never reports as negative.
        sign_q <= neg_q && (|scr_q);
        lz_q   <= lz_calc;
      end
    end
  end

  assign bcd_out  = bcd_q;
  assign sign_out = sign_q;
  assign lz_mask  = lz_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: 8-bit unsigned, 8-bit signed and 16-bit/5-digit instances
// checked with immediate assertions against hand-computed results.
module tb_bin_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bin = '0;
  logic [2:0]  vld = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] u8_bcd, s8_bcd;
  logic [19:0] w16_bcd;
  logic [2:0]  u8_lz, s8_lz;
  logic [4:0]  w16_lz;
  logic        u8_rdy, s8_rdy, w16_rdy;
  logic        u8_sign, s8_sign, w16_sign;
  logic        u8_dv, s8_dv, w16_dv;

  logic [19:0] bcd_a  [3];
  logic [4:0]  lz_a   [3];
  logic        rdy_a  [3];
  logic        sign_a [3];
  logic        dout_a [3];
  logic [19:0] held   [3];

  always #5 clk = ~clk;

  bin_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_u8 (
    .clk(clk), .rst(rst), .bin_in(bin[7:0]), .din_vld(vld[0]), .din_rdy(u8_rdy),
    .bcd_out(u8_bcd), .sign_out(u8_sign), .lz_mask(u8_lz), .dout_vld(u8_dv)
  );

  bin_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_s8 (
    .clk(clk), .rst(rst), .bin_in(bin[7:0]), .din_vld(vld[1]), .din_rdy(s8_rdy),
    .bcd_out(s8_bcd), .sign_out(s8_sign), .lz_mask(s8_lz), .dout_vld(s8_dv)
  );

  bin_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_w16 (
    .clk(clk), .rst(rst), .bin_in(bin), .din_vld(vld[2]), .din_rdy(w16_rdy),
    .bcd_out(w16_bcd), .sign_out(w16_sign), .lz_mask(w16_lz), .dout_vld(w16_dv)
  );

  assign bcd_a[0]  = {8'd0, u8_bcd};
  assign bcd_a[1]  = {8'd0, s8_bcd};
  assign bcd_a[2]  = w16_bcd;
  assign lz_a[0]   = {2'd0, u8_lz};
  assign lz_a[1]   = {2'd0, s8_lz};
  assign lz_a[2]   = w16_lz;
  assign rdy_a[0]  = u8_rdy;
  assign rdy_a[1]  = s8_rdy;
  assign rdy_a[2]  = w16_rdy;
  assign sign_a[0] = u8_sign;
  assign sign_a[1] = s8_sign;
  assign sign_a[2] = w16_sign;
  assign dout_a[0] = u8_dv;
  assign dout_a[1] = s8_dv;
  assign dout_a[2] = w16_dv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One conversion on instance s: single-cycle valid, then latency, ready and result checks.
  task automatic convert(input int s, input logic [15:0] val, input logic [19:0] eb,
                         input logic es, input logic [4:0] elz, input string tag);
    int   n, lows, lat;
    logic seen;
    lat = (s == 2) ? 17 : 9;
    check({tag, "_rdy_idle"}, 32'(rdy_a[s]), 32'd1);
    bin    = val;
    vld[s] = 1'b1;
    @(posedge clk);
    #1;
    vld[s] = 1'b0;
    bin    = 16'($urandom);
    check({tag, "_hold"}, 32'(bcd_a[s]), 32'(held[s]));
    lows = rdy_a[s] ? 0 : 1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (dout_a[s]) seen = 1'b1;
      else if (!rdy_a[s]) lows++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_rdy_low"}, 32'(lows), 32'(lat));
    check({tag, "_bcd"}, 32'(bcd_a[s]), 32'(eb));
    check({tag, "_sign"}, 32'(sign_a[s]), 32'(es));
    check({tag, "_lz"}, 32'(lz_a[s]), 32'(elz));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(dout_a[s]), 32'd0);
    held[s] = eb;
  endtask

  initial begin
    int          acc, got, cyc, last_acc, next_v, pulses;
    logic        rdy_before;
    logic [7:0]  exp_q [$];
    logic [7:0]  v;

    for (int s = 0; s < 3; s++) held[s] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      check("rst_bcd", 32'(bcd_a[s]), 32'd0);
      check("rst_lz", 32'(lz_a[s]), (s == 2) ? 32'h1e : 32'h6);
      check("rst_sign", 32'(sign_a[s]), 32'd0);
      check("rst_dvld", 32'(dout_a[s]), 32'd0);
      check("rst_rdy", 32'(rdy_a[s]), 32'd1);
    end

    // Unsigned 8-bit, 3 digits
    convert(0, 16'h00ff, 20'h00255, 1'b0, 5'b00000, "u8_ff");
    convert(0, 16'h0000, 20'h00000, 1'b0, 5'b00110, "u8_zero");
    convert(0, 16'd7,    20'h00007, 1'b0, 5'b00110, "u8_7");
    convert(0, 16'd40,   20'h00040, 1'b0, 5'b00100, "u8_40");
    convert(0, 16'd109,  20'h00109, 1'b0, 5'b00000, "u8_109");

    // Signed 8-bit
    convert(1, 16'h0080, 20'h00128, 1'b1, 5'b00000, "s8_80");
    convert(1, 16'h00ff, 20'h00001, 1'b1, 5'b00110, "s8_ff");
    convert(1, 16'h007f, 20'h00127, 1'b0, 5'b00000, "s8_7f");
    convert(1, 16'h0000, 20'h00000, 1'b0, 5'b00110, "s8_zero");
    convert(1, 16'h00f6, 20'h00010, 1'b1, 5'b00100, "s8_m10");

    // 16-bit, 5 digits
    convert(2, 16'hffff, 20'h65535, 1'b0, 5'b00000, "w16_max");
    convert(2, 16'd5,    20'h00005, 1'b0, 5'b11110, "w16_5");
    convert(2, 16'd1000, 20'h01000, 1'b0, 5'b10000, "w16_1000");

    // Back-to-back on the 8-bit unsigned instance with valid held high
    acc      = 0;
    got      = 0;
    cyc      = 0;
    last_acc = 0;
    next_v   = 0;
    bin      = 16'd0;
    vld[0]   = 1'b1;
    while (got < 256 && cyc < 3000) begin
      rdy_before = u8_rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy_before && vld[0]) begin
        exp_q.push_back(8'(next_v));
        if (acc > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        acc++;
        if (acc == 256) vld[0] = 1'b0;
        else begin
          next_v++;
          bin = 16'(next_v);
        end
      end
      if (u8_dv) begin
        got++;
        if (exp_q.size() == 0) begin
          check("b2b_spurious", 32'd1, 32'd0);
        end else begin
          v = exp_q.pop_front();
          check("b2b_bcd", 32'(bcd_a[0]), 32'(to_bcd(int'(v))));
        end
      end
    end
    vld[0] = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd256);
    check("b2b_results", 32'(got), 32'd256);
    held[0] = 20'h00255;

    // Reset sampled on shift edge 4 of a conversion of 200
    bin    = 16'd200;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_bcd", 32'(bcd_a[0]), 32'd0);
    check("mid_rst_lz", 32'(lz_a[0]), 32'h6);
    check("mid_rst_sign", 32'(sign_a[0]), 32'd0);
    check("mid_rst_rdy", 32'(rdy_a[0]), 32'd1);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (u8_dv) pulses++;
    end
    check("mid_rst_no_dvld", 32'(pulses), 32'd0);
    for (int s = 0; s < 3; s++) held[s] = '0;

    convert(0, 16'd200, 20'h00200, 1'b0, 5'b00000, "u8_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
